tri_assembly_fifo: RTL and testbench
====================================

Name: tri_assembly_fifo

Overview:
- Sits between `transformation` (one 4-coordinate vertex per valid) and `tri_proj`.
- Gathers VERTS consecutive vertices into one triangle and buffers triangles in a DEPTH-entry FIFO.
- Carries object-done markers in order with the triangles.
- Supports two full-FIFO policies: backpressure the source, or drop the newest triangle and count the drop.

Parameters:
- DATA_W, 32, width of one coordinate word (IEEE float bits, opaque here)
- COORDS, 4, words per vertex
- VERTS, 3, vertices per triangle
- DEPTH, 16, FIFO entries (power of two, >=2)
- DROP_MODE, 0, 0 = backpressure on full, 1 = drop completed triangle on full
- CNT_W, 16, width of drop/discard counters

Ports:
- clk_in  in  1  pixel clock
- rst_in  in  1  asynchronous, active-low reset
- flush_in  in  1  synchronous clear of assembler, FIFO and pending marker
- vert_in  in  COORDS x DATA_W  vertex words, [0] = x
- vert_valid_in  in  1  vertex present
- obj_done_in  in  1  end-of-object pulse, uses the same handshake as vertices
- vert_ready_out  out  1  block accepts vertex or marker this cycle
- tri_out  out  VERTS x COORDS x DATA_W  head triangle
- marker_out  out  1  head entry is an object-done marker (tri_out don't-care)
- out_valid_out  out  1  head entry valid
- out_ready_in  in  1  consumer pops head
- count_out  out  $clog2(DEPTH+1)  occupied entries
- drop_count_out  out  CNT_W  triangles dropped (DROP_MODE=1), saturating
- discard_count_out  out  CNT_W  partial triangles discarded by obj_done_in, saturating

Behaviour:
- Reset (rst_in low, async) values:
  - FIFO empty; vert index = 0; pending marker cleared.
  - out_valid_out=0, marker_out=0, count_out=0, both counters=0.
  - vert_ready_out=0 while in reset, 1 from the first edge after release.
- Accept rule: vertex accepted on an edge where vert_valid_in & vert_ready_out.
- Assembler: index counter 0..VERTS-1.
  - An accepted vertex is stored to slot[index] and index increments.
  - On slot VERTS-1, the triangle is pushed and index wraps to 0.
- vert_ready_out:
  - DROP_MODE=0: high when not full and no pending marker.
  - DROP_MODE=1: high whenever no pending marker.
- obj_done_in, accepted when obj_done_in & vert_ready_out:
  - If index != 0, the partial triangle is discarded, discard_count_out increments and index is set to 0.
  - A marker entry is then pushed.
  - If the FIFO is full, the marker is held pending and vert_ready_out is low until it is written; markers are never dropped.
- obj_done_in and vert_valid_in together in the same accepted cycle: the vertex is processed first, then the marker.
  - If the vertex completes a triangle, the triangle is pushed this edge and the marker goes pending (written next cycle at the earliest).
- Latency: push at edge N gives out_valid_out high from edge N (registered head, readable cycle N+1). No same-cycle bypass from input to output.
- Pop: on out_valid_out & out_ready_in; tri_out and marker_out are presented from registered memory, first-word-fall-through.
- Push and pop in the same cycle: count_out unchanged; allowed when full because the pop frees the slot.
- DROP_MODE=1, full, no pop, triangle completes: triangle discarded, drop_count_out increments (saturates at all-ones), index still wraps.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full is count_out==DEPTH, empty is count_out==0.
- flush_in:
  - Next edge: FIFO empty, index=0, pending marker cleared, out_valid_out=0.
  - Counters retained.
  - Inputs presented in the flush cycle are ignored.
- Asynchronous reset mid-packet: all state lost; no partial output.

Decomposition:
- Package `tri_pkg`:
  - typedef `vertex_t` (COORDS x DATA_W)
  - typedef `triangle_t` (VERTS x vertex_t)
  - struct `tri_entry_t` {marker, triangle_t}
  - constants NUM_COORDS=4, NUM_VERTS=3
- Sub-module `sync_fifo` (parametrised width/depth, FWFT, count, full/empty) holds `tri_entry_t`.
- The assembler, marker logic and counters live in `tri_assembly_fifo`.

Test Plan:
- Basic assembly:
  - Stimulus: 6 vertices with x=1..6, out_ready_in=1.
  - Required: two triangles out, with x words {1,2,3} then {4,5,6}; marker_out=0; count_out back to 0.
- Backpressure (DROP_MODE=0, DEPTH=4):
  - Stimulus: out_ready_in=0, push 15 vertices.
  - Required: vert_ready_out low after the 12th accepted vertex; the 13th is stalled; count_out=4.
- Drop mode (DROP_MODE=1, DEPTH=4):
  - Stimulus: out_ready_in=0, push 18 vertices.
  - Required: count_out=4, drop_count_out=2; head triangle contains x={1,2,3}.
- Marker ordering:
  - Stimulus: 2 vertices, then obj_done_in, then 3 vertices.
  - Required: discard_count_out=1; output is a marker entry, then one triangle.
- Simultaneous vertex and done:
  - Stimulus: 3rd vertex with obj_done_in=1.
  - Required: triangle entry followed by a marker entry; vert_ready_out low for exactly one cycle.
- Flush and reset:
  - Stimulus: flush_in with count_out=3 and index=1.
  - Required: count_out=0, out_valid_out=0, and the next 3 vertices form a fresh triangle.
  - Stimulus: rst_in low mid-stream.
  - Required: all outputs at their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tri_pkg.sv
// tri_pkg: shared vertex/triangle/FIFO-entry types for the triangle assembler.
package tri_pkg;
  localparam int NUM_COORDS = 4;
  localparam int NUM_VERTS = 3;
  localparam int WORD_W = 32;
  typedef logic [NUM_COORDS-1:0][WORD_W-1:0] vertex_t;
  typedef vertex_t [NUM_VERTS-1:0] triangle_t;
  typedef struct packed {
    logic marker;
    triangle_t tri_data;
  } tri_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count and synchronous flush.
// Ports: clk_in/rst_in (async active-low), flush_in clears, wr_in/wdata_in push,
// rd_in pops head, rdata_out head word, count_out occupancy, full_out/empty_out flags.
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         flush_in,
  input  logic                         wr_in,
  input  logic [W-1:0]                 wdata_in,
  input  logic                         rd_in,
  output logic [W-1:0]                 rdata_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out,
  output logic                         full_out,
  output logic                         empty_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic w_rd, w_wr;
  assign empty_out = r_count == '0;
  assign full_out = r_count == CW'(DEPTH);
  assign w_rd = rd_in & ~empty_out;
  // a pop frees a slot in the same cycle, so a full FIFO can still accept a push
  assign w_wr = wr_in & (~full_out | w_rd);
  assign count_out = r_count;
  assign rdata_out = r_mem[r_rptr];
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else if (flush_in) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      r_wptr <= r_wptr + AW'(w_wr);
      r_rptr <= r_rptr + AW'(w_rd);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end
  always_ff @(posedge clk_in) begin
    if (w_wr & ~flush_in) r_mem[r_wptr] <= wdata_in;
  end
endmodule

// File: rtl/tri_assembly_fifo.sv
// tri_assembly_fifo: groups vertices into triangles and queues them with object-done markers.
// Ports: clk_in/rst_in (async active-low), flush_in sync clear; vert_in/vert_valid_in/obj_done_in
// input side with vert_ready_out; tri_out/marker_out/out_valid_out head entry popped by
// out_ready_in; count_out occupancy; drop_count_out/discard_count_out saturating counters.
module tri_assembly_fifo
  import tri_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int COORDS = NUM_COORDS,
  parameter int VERTS = NUM_VERTS,
  parameter int DEPTH = 16,
  parameter int DROP_MODE = 0,
  parameter int CNT_W = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              flush_in,
  input  logic [COORDS*DATA_W-1:0]          vert_in,
  input  logic                              vert_valid_in,
  input  logic                              obj_done_in,
  output logic                              vert_ready_out,
  output logic [VERTS*COORDS*DATA_W-1:0]    tri_out,
  output logic                              marker_out,
  output logic                              out_valid_out,
  input  logic                              out_ready_in,
  output logic [$clog2(DEPTH+1)-1:0]        count_out,
  output logic [CNT_W-1:0]                  drop_count_out,
  output logic [CNT_W-1:0]                  discard_count_out
);
  localparam int IW = $clog2(VERTS);
  logic r_live, r_pend;
  logic [IW-1:0] r_idx;
  triangle_t r_slots;
  logic [CNT_W-1:0] r_drop, r_disc;
  logic w_full, w_empty, w_pop, w_can_push, w_ready;
  logic w_acc_v, w_acc_d, w_last, w_tri_push, w_drop, w_mark_wr, w_disc, w_wr;
  triangle_t w_tri;
  tri_entry_t w_entry, w_head;
  assign w_pop = out_ready_in & ~w_empty;
  assign w_can_push = ~w_full | w_pop;
  // r_live holds ready low until the first edge after reset release
  assign w_ready = r_live & ~r_pend & ((DROP_MODE != 0) | ~w_full);
  assign w_acc_v = vert_valid_in & w_ready & ~flush_in;
  assign w_acc_d = obj_done_in & w_ready & ~flush_in;
  assign w_last = w_acc_v & (r_idx == IW'(VERTS-1));
  assign w_tri_push = w_last & w_can_push;
  assign w_drop = w_last & ~w_can_push;
  // a marker behind a triangle completed this edge always waits one cycle in r_pend
  assign w_mark_wr = w_can_push & (r_pend | (w_acc_d & ~w_last));
  // the vertex is applied before the marker, so a fresh vertex makes the triangle partial
  assign w_disc = w_acc_d & ~w_last & (w_acc_v | (r_idx != '0));
  assign w_wr = w_tri_push | w_mark_wr;
  always_comb begin
    w_tri = r_slots;
    w_tri[VERTS-1] = vert_in;
    w_entry = '{marker: w_mark_wr, tri_data: w_tri};
  end
  sync_fifo #(.W($bits(tri_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .flush_in (flush_in),
    .wr_in    (w_wr),
    .wdata_in (w_entry),
    .rd_in    (out_ready_in),
    .rdata_out(w_head),
    .count_out(count_out),
    .full_out (w_full),
    .empty_out(w_empty)
  );
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_live <= 1'b0;
      r_pend <= 1'b0;
      r_idx <= '0;
      r_drop <= '0;
      r_disc <= '0;
    end else begin
      r_live <= 1'b1;
      r_drop <= r_drop + CNT_W'(w_drop & ~&r_drop);
      r_disc <= r_disc + CNT_W'(w_disc & ~&r_disc);
      if (flush_in) begin
        r_pend <= 1'b0;
        r_idx <= '0;
      end else begin
        r_pend <= (w_acc_d & (w_last | ~w_can_push)) | (r_pend & ~w_can_push);
        r_idx <= (w_acc_d | w_last) ? '0 : w_acc_v ? r_idx + IW'(1) : r_idx;
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (w_acc_v & ~w_last) r_slots[r_idx] <= vert_in;
  end
  assign vert_ready_out = w_ready;
  assign out_valid_out = ~w_empty;
  assign marker_out = w_head.marker & ~w_empty;
  assign tri_out = w_head.tri_data;
  assign drop_count_out = r_drop;
  assign discard_count_out = r_disc;
endmodule

// File: tb/tb_tri_assembly_fifo.sv
// tb_tri_assembly_fifo: drives backpressure and drop-mode instances against a queue-based model.
module tb_tri_assembly_fifo;
  typedef logic [384:0] ent_t;
  typedef struct {
    bit v;
    logic [31:0] x;
    bit ordy;
    bit ev;
    logic [31:0] ex0, ex1, ex2;
    int ecnt;
  } vec_t;
  logic clk_in, rst_in, flush_in, vert_valid_in, obj_done_in, out_ready_in;
  logic [127:0] vert_in;
  logic [1:0] rdy, mk, ov;
  logic [383:0] tri_o [2];
  logic [2:0] cnt [2];
  logic [15:0] drp [2], dsc [2];
  int errors = 0, checks = 0;
  ent_t mq [2][$];
  logic [127:0] ms [2][3];
  int midx [2];
  bit mpend [2], mlive [2];
  logic [15:0] mdrop [2], mdisc [2];
  vec_t tbl [7];
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    tri_assembly_fifo #(.DATA_W(32), .COORDS(4), .VERTS(3), .DEPTH(4), .DROP_MODE(g), .CNT_W(16)) u_dut (
      .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .vert_in(vert_in),
      .vert_valid_in(vert_valid_in), .obj_done_in(obj_done_in), .vert_ready_out(rdy[g]),
      .tri_out(tri_o[g]), .marker_out(mk[g]), .out_valid_out(ov[g]), .out_ready_in(out_ready_in),
      .count_out(cnt[g]), .drop_count_out(drp[g]), .discard_count_out(dsc[g])
    );
  end
  task automatic chk(string name, logic [383:0] act, logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic bit mrdy(int m);
    return mlive[m] && !mpend[m] && (m == 1 || mq[m].size() < 4);
  endfunction
  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      midx[m] = 0;
      mpend[m] = 0;
      mlive[m] = 0;
      mdrop[m] = 0;
      mdisc[m] = 0;
    end
  endtask
  task automatic mstep(int m, bit v, logic [127:0] vd, bit d, bit ordy, bit fl);
    bit ready, pop, room, tri_done;
    ready = mrdy(m);
    mlive[m] = 1;
    if (fl) begin
      mq[m].delete();
      midx[m] = 0;
      mpend[m] = 0;
      return;
    end
    pop = mq[m].size() > 0 && ordy;
    room = mq[m].size() < 4 || pop;
    if (pop) void'(mq[m].pop_front());
    if (mpend[m]) begin
      if (room) begin
        mq[m].push_back({1'b1, 384'b0});
        mpend[m] = 0;
      end
    end else if (ready) begin
      tri_done = 0;
      if (v) begin
        ms[m][midx[m]] = vd;
        if (midx[m] == 2) begin
          tri_done = 1;
          midx[m] = 0;
          if (room) mq[m].push_back({1'b0, ms[m][2], ms[m][1], ms[m][0]});
          else if (mdrop[m] != 16'hffff) mdrop[m]++;
        end else midx[m]++;
      end
      if (d) begin
        if (tri_done) mpend[m] = 1;
        else begin
          if (midx[m] != 0) begin
            if (mdisc[m] != 16'hffff) mdisc[m]++;
            midx[m] = 0;
          end
          if (room) mq[m].push_back({1'b1, 384'b0});
          else mpend[m] = 1;
        end
      end
    end
  endtask
  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("valid[%0d]", m), ov[m], mq[m].size() > 0);
      chk($sformatf("marker[%0d]", m), mk[m], mq[m].size() > 0 ? mq[m][0][384] : 1'b0);
      if (mq[m].size() > 0 && !mq[m][0][384]) chk($sformatf("tri[%0d]", m), tri_o[m], mq[m][0][383:0]);
      chk($sformatf("count[%0d]", m), cnt[m], mq[m].size());
      chk($sformatf("drop[%0d]", m), drp[m], mdrop[m]);
      chk($sformatf("discard[%0d]", m), dsc[m], mdisc[m]);
    end
  endtask
  task automatic step(bit v, logic [127:0] vd, bit d, bit ordy, bit fl);
    vert_valid_in = v;
    vert_in = vd;
    obj_done_in = d;
    out_ready_in = ordy;
    flush_in = fl;
    #1;
    for (int m = 0; m < 2; m++) chk($sformatf("ready[%0d]", m), rdy[m], mrdy(m));
    for (int m = 0; m < 2; m++) mstep(m, v, vd, d, ordy, fl);
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask
  function automatic logic [127:0] mkv(logic [31:0] x);
    return {$urandom(), $urandom(), $urandom(), x};
  endfunction
  task automatic chk_head_x(int m, logic [31:0] a, logic [31:0] b, logic [31:0] c);
    chk($sformatf("head_x0[%0d]", m), tri_o[m][31:0], a);
    chk($sformatf("head_x1[%0d]", m), tri_o[m][159:128], b);
    chk($sformatf("head_x2[%0d]", m), tri_o[m][287:256], c);
  endtask
  task automatic chk_reset_outputs(string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_valid[%0d]", tag, m), ov[m], 1'b0);
      chk($sformatf("%s_marker[%0d]", tag, m), mk[m], 1'b0);
      chk($sformatf("%s_count[%0d]", tag, m), cnt[m], 3'd0);
      chk($sformatf("%s_drop[%0d]", tag, m), drp[m], 16'd0);
      chk($sformatf("%s_discard[%0d]", tag, m), dsc[m], 16'd0);
      chk($sformatf("%s_ready[%0d]", tag, m), rdy[m], 1'b0);
    end
  endtask
  initial begin
    tbl[0] = '{1, 1, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 2, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 3, 1, 1, 1, 2, 3, 1};
    tbl[3] = '{1, 4, 1, 0, 0, 0, 0, 0};
    tbl[4] = '{1, 5, 1, 0, 0, 0, 0, 0};
    tbl[5] = '{1, 6, 1, 1, 4, 5, 6, 1};
    tbl[6] = '{0, 0, 1, 0, 0, 0, 0, 0};
    rst_in = 1'b0;
    flush_in = 1'b0;
    vert_valid_in = 1'b0;
    obj_done_in = 1'b0;
    out_ready_in = 1'b0;
    vert_in = '0;
    mreset();
    repeat (2) @(posedge clk_in);
    #1;
    chk_reset_outputs("init");
    rst_in = 1'b1;
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, mkv(tbl[i].x), 0, tbl[i].ordy, 0);
      chk($sformatf("tbl_valid%0d", i), ov[0], tbl[i].ev);
      chk($sformatf("tbl_count%0d", i), cnt[0], 3'(tbl[i].ecnt));
      if (tbl[i].ev) chk_head_x(0, tbl[i].ex0, tbl[i].ex1, tbl[i].ex2);
    end
    for (int i = 1; i <= 18; i++) begin
      step(1, mkv(32'(i)), 0, 0, 0);
      if (i == 11) chk("bp_ready_before_full", rdy[0], 1'b1);
      if (i == 12) chk("bp_ready_after_12", rdy[0], 1'b0);
    end
    chk("bp_count", cnt[0], 3'd4);
    chk("drop_count", cnt[1], 3'd4);
    chk("drop_drops", drp[1], 16'd2);
    chk_head_x(0, 1, 2, 3);
    chk_head_x(1, 1, 2, 3);
    repeat (5) step(0, 0, 0, 1, 0);
    step(1, mkv(21), 0, 0, 0);
    step(1, mkv(22), 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 23; i <= 25; i++) step(1, mkv(32'(i)), 0, 0, 0);
    chk("mo_discard0", dsc[0], 16'd1);
    chk("mo_discard1", dsc[1], 16'd1);
    chk("mo_head_marker", mk[0], 1'b1);
    step(0, 0, 0, 1, 0);
    chk("mo_second_marker", mk[0], 1'b0);
    chk_head_x(0, 23, 24, 25);
    step(0, 0, 0, 1, 0);
    step(1, mkv(41), 0, 0, 0);
    step(1, mkv(42), 0, 0, 0);
    step(1, mkv(43), 1, 0, 0);
    chk("sim_ready_low", rdy[0], 1'b0);
    chk("sim_head_tri", mk[0], 1'b0);
    chk_head_x(0, 41, 42, 43);
    step(0, 0, 0, 0, 0);
    chk("sim_ready_back", rdy[0], 1'b1);
    chk("sim_count", cnt[0], 3'd2);
    step(0, 0, 0, 1, 0);
    chk("sim_then_marker", mk[0], 1'b1);
    step(0, 0, 0, 1, 0);
    for (int i = 51; i <= 60; i++) step(1, mkv(32'(i)), 0, 0, 0);
    chk("fl_pre_count", cnt[0], 3'd3);
    step(1, mkv(99), 1, 1, 1);
    chk("fl_count", cnt[0], 3'd0);
    chk("fl_valid", ov[0], 1'b0);
    for (int i = 61; i <= 63; i++) step(1, mkv(32'(i)), 0, 0, 0);
    chk_head_x(0, 61, 62, 63);
    chk("fl_fresh_count", cnt[1], 3'd1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, mkv($urandom()), $urandom_range(0, 99) < 8,
           $urandom_range(0, 1), $urandom_range(0, 99) < 1);
    for (int i = 0; i < 8; i++) step(1, mkv($urandom()), 0, 0, 0);
    rst_in = 1'b0;
    #1;
    chk_reset_outputs("async");
    mreset();
    #3;
    rst_in = 1'b1;
    for (int i = 0; i < 20; i++)
      step($urandom_range(0, 1), mkv($urandom()), $urandom_range(0, 9) < 1, $urandom_range(0, 1), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
